// File: rtl/pio_shot_sequencer.sv
// Shot sequencer: copies NUM_PIO shadow words to PIO slaves over a write-only
// Avalon master, pulses tx_trig, then waits out the shot period, SHOTS times.
module pio_shot_sequencer #(
  parameter int NUM_PIO  = 4,
  parameter int PERIOD_W = 24,
  parameter int SHOT_W   = 16,
  parameter int TX_PULSE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cfg_address,
  input  logic               cfg_chipselect,
  input  logic               cfg_write_n,
  input  logic [31:0]        cfg_writedata,
  output logic [31:0]        cfg_readdata,
  output logic [NUM_PIO-1:0] m_chipselect,
  output logic [1:0]         m_address,
  output logic               m_write_n,
  output logic [31:0]        m_writedata,
  output logic               tx_trig,
  output logic               busy,
  output logic               irq
);
  localparam int IDX_W = (NUM_PIO > 1) ? $clog2(NUM_PIO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [PERIOD_W-1:0]       cnt, cnt_nxt;
  logic [SHOT_W-1:0]         shot_cnt, shot_nxt, shot_inc;
  logic [SHOT_W-1:0]         wshots, wshots_nxt;
  logic [PERIOD_W-1:0]       wperiod, wperiod_nxt;
  logic                      done, done_nxt, irq_nxt, aborted, aborted_nxt;
  logic                      shot_done, load_nxt;
  logic [SHOT_W-1:0]         shots_reg;
  logic [PERIOD_W-1:0]       period_reg;
  logic [NUM_PIO-1:0][31:0]  shadow;

  logic cfg_wr, ctrl_wr, start_req, abort_req, status_clr;
  assign cfg_wr     = cfg_chipselect & ~cfg_write_n;
  assign ctrl_wr    = cfg_wr && (cfg_address == 4'd0);
  assign abort_req  = ctrl_wr & cfg_writedata[1];
  assign start_req  = ctrl_wr & cfg_writedata[0] & ~cfg_writedata[1];
  assign status_clr = cfg_wr && (cfg_address == 4'd1) && cfg_writedata[1];
  assign shot_inc   = shot_cnt + SHOT_W'(1);
  assign busy       = (state != S_IDLE);
  assign m_address  = 2'd0;

  // Host-visible configuration; working copies are latched only at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shots_reg  <= '0;
      period_reg <= '0;
      shadow     <= '0;
    end else if (cfg_wr) begin
      if (cfg_address == 4'd2) shots_reg  <= cfg_writedata[SHOT_W-1:0];
      if (cfg_address == 4'd3) period_reg <= cfg_writedata[PERIOD_W-1:0];
      for (int k = 0; k < NUM_PIO; k++)
        if (cfg_address == 4'(4 + k)) shadow[k] <= cfg_writedata;
    end
  end

  always_comb begin
    cfg_readdata = '0;
    case (cfg_address)
      4'd1:    cfg_readdata = {16'(shot_cnt), 13'd0, aborted, done, busy};
      4'd2:    cfg_readdata = 32'(shots_reg);
      4'd3:    cfg_readdata = 32'(period_reg);
      default: ;
    endcase
    for (int k = 0; k < NUM_PIO; k++)
      if (cfg_address == 4'(4 + k)) cfg_readdata = shadow[k];
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    shot_nxt    = shot_cnt;
    wshots_nxt  = wshots;
    wperiod_nxt = wperiod;
    done_nxt    = done;
    irq_nxt     = irq;
    aborted_nxt = aborted;
    shot_done   = 1'b0;
    if (status_clr) begin
      done_nxt = 1'b0;
      irq_nxt  = 1'b0;
    end
    if (abort_req && state != S_IDLE) begin
      state_nxt   = S_IDLE;
      aborted_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start_req) begin
          done_nxt    = 1'b0;
          aborted_nxt = 1'b0;
          shot_nxt    = '0;
          wshots_nxt  = shots_reg;
          wperiod_nxt = period_reg;
          if (shots_reg == '0) begin
            done_nxt = 1'b1;
            irq_nxt  = 1'b1;
          end else begin
            state_nxt = S_LOAD;
            idx_nxt   = '0;
          end
        end
        S_LOAD: if (idx == IDX_W'(NUM_PIO - 1)) begin
          state_nxt = S_FIRE;
          cnt_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
        S_FIRE: if (cnt == PERIOD_W'(TX_PULSE - 1)) begin
          if (wperiod == '0) shot_done = 1'b1;
          else begin
            state_nxt = S_WAIT;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + PERIOD_W'(1);
        end
        S_WAIT: if (cnt == wperiod - PERIOD_W'(1)) shot_done = 1'b1;
                else cnt_nxt = cnt + PERIOD_W'(1);
        default: state_nxt = S_IDLE;
      endcase
      if (shot_done) begin
        shot_nxt = shot_inc;
        if (shot_inc == wshots) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          irq_nxt   = 1'b1;
        end else begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
        end
      end
    end
  end

  // Bus outputs are decoded from the next state so they come straight off flops
  // and line up with the state they belong to.
  assign load_nxt = (state_nxt == S_LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      shot_cnt     <= '0;
      wshots       <= '0;
      wperiod      <= '0;
      done         <= 1'b0;
      irq          <= 1'b0;
      aborted      <= 1'b0;
      m_chipselect <= '0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      tx_trig      <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      shot_cnt     <= shot_nxt;
      wshots       <= wshots_nxt;
      wperiod      <= wperiod_nxt;
      done         <= done_nxt;
      irq          <= irq_nxt;
      aborted      <= aborted_nxt;
      m_chipselect <= load_nxt ? (NUM_PIO'(1) << idx_nxt) : '0;
      m_write_n    <= ~load_nxt;
      m_writedata  <= load_nxt ? shadow[idx_nxt] : '0;
      tx_trig      <= (state_nxt == S_FIRE);
    end
  end
endmodule
